// File: rtl/diy_mole_recorder_pkg.sv
// Shared types and widths for the DIY mole recorder and the mole timing stage.
package diy_mole_recorder_pkg;

    localparam int MUSIC_ADDR_W = 23;
    localparam int MOLE_IDX_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } rec_state_t;

endpackage

// File: rtl/diy_time_ram.sv
// Stomp-time storage: one write port, one registered read port (BRAM friendly).
module diy_time_ram
    import diy_mole_recorder_pkg::*;
#(
    parameter int DEPTH = 127,
    parameter int AW    = 7
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [MUSIC_ADDR_W-1:0] wdata,
    input  logic [AW-1:0]           raddr,
    output logic [MUSIC_ADDR_W-1:0] rdata
);

    logic [MUSIC_ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/diy_mole_recorder.sv
// Records stomp times (music sample addresses) in DIY mode and serves them
// back to the mole timing stage by index.
module diy_mole_recorder
    import diy_mole_recorder_pkg::*;
#(
    parameter int                      MAX_ITEM   = 127,
    parameter int                      INDEX_BITS = MOLE_IDX_W,
    parameter logic [MUSIC_ADDR_W-1:0] MIN_GAP    = 23'h1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    diy_mode,
    input  logic                    record_stomp,
    input  logic                    finish,
    input  logic [MUSIC_ADDR_W-1:0] music_address,
    input  logic [INDEX_BITS-1:0]   lookup_index,
    output logic [23:0]             index_address,
    output logic [INDEX_BITS-1:0]   total_moles,
    output logic                    ready_to_use,
    output logic                    recording,
    output logic                    full
);

    localparam int AW = $clog2(MAX_ITEM);
    localparam logic [INDEX_BITS-1:0] MAX_CNT = INDEX_BITS'(MAX_ITEM);

    rec_state_t state, state_next;

    logic [MUSIC_ADDR_W-1:0] last;
    logic [INDEX_BITS-1:0]   count_next;
    logic [MUSIC_ADDR_W:0]   threshold;
    logic                    eligible;
    logic                    accept;
    logic                    wrapped;
    logic                    enter_record;
    logic [INDEX_BITS-1:0]   rd_idx;
    logic [MUSIC_ADDR_W-1:0] rd_data;
    logic                    rd_zero;

    // 24-bit sum so a late stomp near the end of the song cannot wrap past zero
    assign threshold = {1'b0, last} + {1'b0, MIN_GAP};
    assign eligible  = (total_moles == '0) || ({1'b0, music_address} >= threshold);
    assign accept    = (state == RECORD) && diy_mode && record_stomp
                       && eligible && (total_moles != MAX_CNT);
    assign wrapped   = (total_moles != '0) && (music_address < last);

    assign enter_record = (state == IDLE) && diy_mode;

    always_comb begin
        state_next = state;
        count_next = total_moles;
        unique case (state)
            IDLE: begin
                if (diy_mode) begin
                    state_next = RECORD;
                    count_next = '0;
                end
            end
            RECORD: begin
                if (!diy_mode) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    if (accept) begin
                        count_next = total_moles + INDEX_BITS'(1);
                    end
                    if (count_next == MAX_CNT) begin
                        state_next = DONE;
                    end else if (finish && (count_next != '0)) begin
                        state_next = DONE;
                    end else if (wrapped) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!diy_mode) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            total_moles  <= '0;
            last         <= '0;
            ready_to_use <= 1'b0;
            recording    <= 1'b0;
            full         <= 1'b0;
            rd_zero      <= 1'b1;
        end else begin
            state        <= state_next;
            total_moles  <= count_next;
            ready_to_use <= (state_next == DONE);
            recording    <= (state_next == RECORD);
            full         <= (count_next == MAX_CNT);
            rd_zero      <= (total_moles == '0);
            if (enter_record) begin
                last <= '0;
            end else if (accept) begin
                last <= music_address;
            end
        end
    end

    // Out-of-range lookups fall back to the first entry
    assign rd_idx = (lookup_index < total_moles) ? lookup_index : '0;

    diy_time_ram #(
        .DEPTH (MAX_ITEM),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (accept && !reset),
        .waddr (AW'(total_moles)),
        .wdata (music_address),
        .raddr (AW'(rd_idx)),
        .rdata (rd_data)
    );

    assign index_address = rd_zero ? 24'd0 : {1'b0, rd_data};

endmodule

// File: tb/tb_diy_mole_recorder.sv
// Randomized scoreboard bench for diy_mole_recorder against a queue-based model.
module tb_diy_mole_recorder;

    localparam int MAX = 4;
    localparam int GAP = 'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        diy_mode = 1'b0;
    logic        record_stomp = 1'b0;
    logic        finish = 1'b0;
    logic [22:0] music_address = '0;
    logic [7:0]  lookup_index = '0;
    logic [23:0] index_address;
    logic [7:0]  total_moles;
    logic        ready_to_use;
    logic        recording;
    logic        full;

    always #5 clk = ~clk;

    diy_mole_recorder #(
        .MAX_ITEM (MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .diy_mode      (diy_mode),
        .record_stomp  (record_stomp),
        .finish        (finish),
        .music_address (music_address),
        .lookup_index  (lookup_index),
        .index_address (index_address),
        .total_moles   (total_moles),
        .ready_to_use  (ready_to_use),
        .recording     (recording),
        .full          (full)
    );

    typedef struct {
        int unsigned idx;
        int unsigned total;
        bit          ready;
        bit          rec;
        bit          full;
    } exp_t;

    exp_t exp_q[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model: mode name and a list of recorded times
    typedef enum int {M_IDLE, M_RECORD, M_DONE} mode_t;
    mode_t       m_mode = M_IDLE;
    int unsigned m_times[$];
    int unsigned m_last = 0;

    task automatic model(input bit r, input bit d, input bit s, input bit f,
                         input int unsigned a, input int unsigned li);
        exp_t e;
        int unsigned n;
        bit ok;
        bit dropped;
        n = m_times.size();
        if (r || n == 0) e.idx = 0;
        else if (li < n) e.idx = m_times[li];
        else e.idx = m_times[0];
        if (r) begin
            m_mode = M_IDLE;
            m_times.delete();
            m_last = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (d) begin
                    m_mode = M_RECORD;
                    m_times.delete();
                    m_last = 0;
                end
                M_RECORD: if (!d) begin
                    m_mode = M_IDLE;
                    m_times.delete();
                end else begin
                    dropped = (n > 0) && (a < m_last);
                    ok = s && (n < MAX) && (n == 0 || a >= m_last + GAP);
                    if (ok) begin
                        m_times.push_back(a);
                        m_last = a;
                    end
                    if (m_times.size() == MAX) m_mode = M_DONE;
                    else if (f && m_times.size() > 0) m_mode = M_DONE;
                    else if (dropped) m_mode = M_DONE;
                end
                default: if (!d) m_mode = M_IDLE;
            endcase
        end
        e.total = m_times.size();
        e.ready = (m_mode == M_DONE);
        e.rec   = (m_mode == M_RECORD);
        e.full  = (m_times.size() == MAX);
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit d, input bit s, input bit f,
                        input int unsigned a, input int unsigned li);
        @(negedge clk);
        reset         = r;
        diy_mode      = d;
        record_stomp  = s;
        finish        = f;
        music_address = a[22:0];
        lookup_index  = li[7:0];
        model(r, d, s, f, a, li);
    endtask

    task automatic check(input string name, input int unsigned act,
                         input int unsigned req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("index_address", index_address, e.idx);
            check("total_moles", total_moles, e.total);
            check("ready_to_use", ready_to_use, e.ready);
            check("recording", recording, e.rec);
            check("full", full, e.full);
        end
    end

    task automatic rearm();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int unsigned addr;
        bit r, d, s, f;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // basic record + playback
        step(0, 1, 0, 0, 'h100, 0);
        step(0, 1, 1, 0, 'h6CDE, 0);
        step(0, 1, 0, 0, 'h7000, 0);
        step(0, 1, 1, 0, 'h8B00, 0);
        step(0, 1, 1, 0, 'hE900, 0);
        step(0, 1, 0, 1, 'hF000, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 'hF100, i);
        // debounce gap
        rearm();
        step(0, 1, 1, 0, 'h10000, 0);
        step(0, 1, 1, 0, 'h10800, 0);
        step(0, 1, 1, 0, 'h11000, 1);
        step(0, 1, 0, 1, 'h11100, 1);
        step(0, 1, 0, 0, 'h11100, 2);
        // fill to capacity
        rearm();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 'h40000 + i * 'h2000, i);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 'h50000, i);
        // stomp and finish together
        rearm();
        step(0, 1, 1, 0, 'h1000, 0);
        step(0, 1, 1, 1, 'h20000, 1);
        step(0, 1, 0, 0, 'h20100, 1);
        step(0, 1, 0, 0, 'h20100, 1);
        // empty finish, then song wrap
        rearm();
        step(0, 1, 0, 1, 'h2F000, 0);
        step(0, 1, 1, 0, 'h30000, 0);
        step(0, 1, 0, 0, 'h100, 0);
        step(0, 1, 0, 0, 'h200, 0);
        // reset mid-record with coincident stomp
        rearm();
        step(0, 1, 1, 0, 'h5000, 0);
        step(1, 1, 1, 0, 'h7000, 0);
        step(0, 0, 0, 0, 'h7000, 0);
        step(0, 1, 0, 0, 'h7000, 0);
        step(0, 1, 1, 0, 'h8000, 0);
        step(0, 1, 1, 0, 'h9000, 0);
        step(0, 1, 1, 0, 'hA000, 0);
        step(0, 1, 0, 1, 'hB000, 0);
        step(0, 0, 0, 0, 'hB000, 9);
        step(0, 0, 0, 0, 'hB000, 9);
        step(0, 0, 0, 0, 'hB000, 2);
        step(0, 0, 0, 0, 'hB000, 2);
        // exact gap boundary and top-of-range compare
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 'h7FE800, 0);
        step(0, 1, 1, 0, 'h7FF7FF, 0);
        step(0, 1, 1, 0, 'h7FF800, 1);
        step(0, 1, 1, 0, 'h7FFFFF, 1);
        step(0, 1, 0, 0, 'h7FFFFF, 2);
        // randomized phase
        addr = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(299) == 0);
            d = ($urandom_range(99) < 96);
            s = ($urandom_range(2) == 0);
            f = ($urandom_range(24) == 0);
            if ($urandom_range(59) == 0 || addr > 'h7FF000)
                addr = $urandom_range(0, 'h7FFFFF);
            else
                addr = addr + $urandom_range(0, 'h1800);
            step(r, d, s, f, addr, $urandom_range(0, 9));
        end
        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched + 1);
        $fatal(1, "timeout");
    end

endmodule
